// File: rtl/messbauer_diff_discriminator_receiver.sv
// Differential-discriminator receiver: classifies lower/upper threshold impulses and publishes per-channel counts.
// Optional MESSBAUER_DISCR_INPUT_SYNC_EN adds a 2-flop synchronizer on every input for asynchronous discriminators.
module messbauer_diff_discriminator_receiver #(
  parameter int COUNTER_WIDTH   = 16,
  parameter int CHANNEL_WIDTH   = 12,
  parameter int CHANNELS        = 4096,
  parameter int MIN_LOWER_WIDTH = 1,
  parameter int MAX_LOWER_WIDTH = 64
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     lower_threshold,
  input  logic                     upper_threshold,
  input  logic                     channel,
  output logic [COUNTER_WIDTH-1:0] accepted_count,
  output logic [COUNTER_WIDTH-1:0] rejected_count,
  output logic [CHANNEL_WIDTH-1:0] channel_number,
  output logic                     count_valid,
  output logic                     overflow
);

  localparam int WW = $clog2(MAX_LOWER_WIDTH + 1);
  localparam logic [WW-1:0] MIN_W = WW'(MIN_LOWER_WIDTH);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_LOWER_WIDTH);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CHANNEL_WIDTH-1:0] LAST_CH = CHANNEL_WIDTH'(CHANNELS - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOWER_HIGH = 2'd1;
  localparam logic [1:0] CLASSIFY   = 2'd2;
  localparam logic [1:0] STUCK      = 2'd3;

  logic [1:0] rst_pipe;
  logic       rst_n;

  // Asserts asynchronously, releases two clocks after areset_n rises.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) rst_pipe <= '0;
    else           rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [2:0] in_raw, in_q;
  logic       lower_prev, channel_prev;
  assign in_raw = {channel, upper_threshold, lower_threshold};

`ifdef MESSBAUER_DISCR_INPUT_SYNC_EN
  logic [2:0] sync1, sync2;
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
    end
  end
`else
  logic [2:0] sync2;
  assign sync2 = in_raw;
`endif

  // NOTE: input history resets high so a line already high at reset release is not seen as a new rising edge.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      in_q         <= '1;
      lower_prev   <= 1'b1;
      channel_prev <= 1'b1;
    end else begin
      in_q         <= sync2;
      lower_prev   <= in_q[0];
      channel_prev <= in_q[2];
    end
  end

  logic lower_rise, lower_fall, chan_rise;
  assign lower_rise = in_q[0] & ~lower_prev;
  assign lower_fall = ~in_q[0] & lower_prev;
  assign chan_rise  = in_q[2] & ~channel_prev;

  logic [1:0]    state, state_next;
  logic [WW-1:0] width, width_next;
  logic          reject, reject_next;
  logic          inc_acc, inc_rej;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    width_next  = width;
    reject_next = reject;
    inc_acc     = 1'b0;
    inc_rej     = 1'b0;
    case (state)
      IDLE: if (lower_rise) begin
        state_next  = LOWER_HIGH;
        width_next  = WW'(1);
        reject_next = in_q[1];
      end
      LOWER_HIGH: begin
        if (in_q[1]) reject_next = 1'b1;
        if (lower_fall) begin
          state_next = CLASSIFY;
        end else if (width == MAX_W) begin
          inc_rej    = 1'b1;
          state_next = STUCK;
        end else begin
          width_next = width + 1'b1;
        end
      end
      CLASSIFY: begin
        if (reject || width < MIN_W) inc_rej = 1'b1;
        else                         inc_acc = 1'b1;
        state_next = IDLE;
      end
      STUCK: if (!in_q[0]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [COUNTER_WIDTH-1:0] acc, rej, acc_sum, rej_sum;
  logic                     acc_sat, rej_sat;
  logic [CHANNEL_WIDTH-1:0] chan_idx;

  assign acc_sat = inc_acc && (acc == CNT_MAX);
  assign rej_sat = inc_rej && (rej == CNT_MAX);
  assign acc_sum = (inc_acc && !acc_sat) ? acc + 1'b1 : acc;
  assign rej_sum = (inc_rej && !rej_sat) ? rej + 1'b1 : rej;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      width          <= '0;
      reject         <= 1'b0;
      acc            <= '0;
      rej            <= '0;
      chan_idx       <= '0;
      accepted_count <= '0;
      rejected_count <= '0;
      channel_number <= '0;
      count_valid    <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state    <= state_next;
      width    <= width_next;
      reject   <= reject_next;
      overflow <= overflow | acc_sat | rej_sat;
      // A classification in the closing cycle still belongs to the closing channel.
      if (chan_rise) begin
        accepted_count <= acc_sum;
        rejected_count <= rej_sum;
        channel_number <= chan_idx;
        count_valid    <= 1'b1;
        acc            <= '0;
        rej            <= '0;
        chan_idx       <= (chan_idx == LAST_CH) ? '0 : chan_idx + 1'b1;
      end else begin
        count_valid <= 1'b0;
        acc         <= acc_sum;
        rej         <= rej_sum;
      end
    end
  end

endmodule

// File: tb/tb_messbauer_diff_discriminator_receiver.sv
// Directed bench for messbauer_diff_discriminator_receiver (COUNTER_WIDTH=4, CHANNELS=4, MIN=3, MAX=64).
module tb_messbauer_diff_discriminator_receiver;

  logic       aclk = 1'b0;
  logic       areset_n;
  logic       lower_threshold, upper_threshold, channel;
  logic [3:0] accepted_count, rejected_count;
  logic [11:0] channel_number;
  logic       count_valid, overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_seen = 0;
  logic [3:0]  cap_acc, cap_rej;
  logic [11:0] cap_ch;

  messbauer_diff_discriminator_receiver #(
    .COUNTER_WIDTH(4), .CHANNEL_WIDTH(12), .CHANNELS(4),
    .MIN_LOWER_WIDTH(3), .MAX_LOWER_WIDTH(64)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .lower_threshold(lower_threshold), .upper_threshold(upper_threshold), .channel(channel),
    .accepted_count(accepted_count), .rejected_count(rejected_count),
    .channel_number(channel_number), .count_valid(count_valid), .overflow(overflow)
  );

  always #5 aclk = ~aclk;

  // Capture every published record away from the active edge.
  always @(negedge aclk) begin
    if (count_valid) begin
      valid_seen <= valid_seen + 1;
      cap_acc    <= accepted_count;
      cap_rej    <= rejected_count;
      cap_ch     <= channel_number;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse(input int len, input int upper_at);
    lower_threshold = 1'b1;
    for (int i = 0; i < len; i++) begin
      upper_threshold = (i == upper_at);
      tick(1);
    end
    lower_threshold = 1'b0;
    upper_threshold = 1'b0;
    tick(10);
  endtask

  task automatic expect_close(input string tag, input int base,
                              input int ea, input int er, input int ech);
    int waited = 0;
    while (valid_seen == base && waited < 20) begin
      tick(1);
      waited++;
    end
    tick(4);
    check({tag, "_valid_pulses"}, valid_seen - base, 1);
    check({tag, "_accepted"}, cap_acc, ea);
    check({tag, "_rejected"}, cap_rej, er);
    check({tag, "_channel"}, cap_ch, ech);
  endtask

  task automatic close_channel(input string tag, input int ea, input int er, input int ech);
    int base = valid_seen;
    channel = 1'b1;
    tick(1);
    channel = 1'b0;
    expect_close(tag, base, ea, er, ech);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_acc"}, accepted_count, 0);
    check({tag, "_rej"}, rejected_count, 0);
    check({tag, "_ch"}, channel_number, 0);
    check({tag, "_valid"}, count_valid, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int base;
    areset_n = 1'b0;
    lower_threshold = 1'b0;
    upper_threshold = 1'b0;
    channel = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    areset_n = 1'b1;
    tick(6);

    // Burst: 5 clean impulses, 11 with upper crossed.
    for (int i = 0; i < 16; i++) pulse(3, (i < 5) ? -1 : 1);
    close_channel("burst", 5, 11, 0);
    check("burst_overflow", overflow, 0);

    // Width limits: too short, stuck, and exactly the maximum.
    pulse(2, -1);
    close_channel("short", 0, 1, 1);
    pulse(70, -1);
    close_channel("stuck", 0, 1, 2);
    pulse(64, -1);
    close_channel("max_width", 1, 0, 3);

    // Upper pulses with lower idle are ignored.
    for (int i = 0; i < 4; i++) begin
      upper_threshold = 1'b1;
      tick(1);
      upper_threshold = 1'b0;
      tick(3);
    end
    close_channel("stray", 0, 0, 0);

    // Classification lands in the same cycle as the channel edge.
    base = valid_seen;
    lower_threshold = 1'b1;
    tick(3);
    lower_threshold = 1'b0;
    tick(1);
    channel = 1'b1;
    tick(1);
    channel = 1'b0;
    expect_close("simul", base, 1, 0, 1);
    close_channel("after_simul", 0, 0, 2);

    // Saturation of a 4-bit counter.
    for (int i = 0; i < 20; i++) pulse(3, -1);
    close_channel("sat", 15, 0, 3);
    check("sat_overflow", overflow, 1);
    close_channel("post_sat", 0, 0, 0);
    check("sticky_overflow", overflow, 1);

    // Reset in the middle of an impulse.
    lower_threshold = 1'b1;
    tick(4);
    areset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    tick(2);
    areset_n = 1'b1;
    tick(5);
    lower_threshold = 1'b0;
    tick(10);

    // Channel index sequence with wrap at CHANNELS=4.
    close_channel("wrap0", 0, 0, 0);
    close_channel("wrap1", 0, 0, 1);
    close_channel("wrap2", 0, 0, 2);
    close_channel("wrap3", 0, 0, 3);
    close_channel("wrap4", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
